// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared types, widths and the round-robin pick helper for the
// I2C command arbiter.
//   arb_state_e : arbiter FSM states
//   I2C_BYTE_W  : width of every byte-wide bus to/from i2c_ctrl
//   rr_pick()   : first set request after the pointer, modulo n, as one-hot
package i2c_arb_pkg;

    localparam int unsigned I2C_BYTE_W = 8;
    localparam int unsigned MAX_REQ    = 8;
    localparam int unsigned MAX_IDX_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        STROBE,
        WAIT_BUSY,
        WAIT_DONE,
        DONE
    } arb_state_e;

    // Search starts one past the last winner so the last winner ranks lowest.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_IDX_W-1:0] ptr,
        input logic [MAX_REQ-1:0]   req,
        input int unsigned          n
    );
        logic [MAX_REQ-1:0] oh;
        logic               found;
        int unsigned        idx;
        oh    = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            if (k <= n && !found) begin
                idx = (32'(ptr) + k) % n;
                if (req[MAX_IDX_W'(idx)]) begin
                    oh[MAX_IDX_W'(idx)] = 1'b1;
                    found               = 1'b1;
                end
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/i2c_arb_rr_arbiter.sv
// i2c_rr_arbiter: round-robin pointer plus combinational one-hot pick.
//   clock_i, reset_i : clock, async active-high reset (pointer -> N_REQ-1)
//   req_i            : request vector
//   update_i         : move the pointer to the current winner
//   pick_c           : one-hot winner (combinational)
module i2c_rr_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic             update_i,
    output logic [N_REQ-1:0] pick_c
);

    localparam int unsigned PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [MAX_REQ-1:0] pick_full;

    always_comb begin
        pick_full = rr_pick(MAX_IDX_W'(ptr_q), MAX_REQ'(req_i), N_REQ);
        pick_c    = pick_full[N_REQ-1:0];
    end

    // Pointer follows the winner only when the grant is actually taken.
    always_comb begin
        ptr_d = ptr_q;
        if (update_i) begin
            for (int i = 0; i < MAX_REQ; i++) begin
                if (pick_full[i]) ptr_d = PTR_W'(i);
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) ptr_q <= PTR_W'(N_REQ - 1);
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: shares one i2c_ctrl between N_REQ requesters, one whole
// command per round-robin grant.
//   req_i/ctrl_wr_i/len_rd_i     : per-requester command request
//   grant_o/done_o/error_o       : registered owner status
//   req_data_*/rd_data_*         : zero-latency data routing to/from owner
//   m_*                          : i2c_ctrl command and data interface
// Optional: define I2C_ARB_TIMEOUT_EN to abort WAIT_BUSY with an error after
// START_TIMEOUT cycles without m_busy_i.
module i2c_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int unsigned N_REQ         = 4,
    parameter int unsigned START_TIMEOUT = 16
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic [N_REQ-1:0]              req_i,
    input  logic [N_REQ*I2C_BYTE_W-1:0]   ctrl_wr_i,
    input  logic [N_REQ*I2C_BYTE_W-1:0]   len_rd_i,
    output logic [N_REQ-1:0]              grant_o,
    output logic [N_REQ-1:0]              done_o,
    output logic [N_REQ-1:0]              error_o,
    input  logic [N_REQ-1:0]              req_data_available_i,
    input  logic [N_REQ*I2C_BYTE_W-1:0]   req_data_i,
    output logic [N_REQ-1:0]              req_data_read_o,
    output logic [N_REQ-1:0]              rd_data_valid_o,
    output logic [I2C_BYTE_W-1:0]         rd_data_o,
    output logic                          m_cmd_strobe_o,
    output logic [I2C_BYTE_W-1:0]         m_ctrl_wr_o,
    output logic [I2C_BYTE_W-1:0]         m_len_rd_o,
    output logic                          m_data_available_o,
    output logic [I2C_BYTE_W-1:0]         m_data_o,
    input  logic                          m_data_read_i,
    input  logic                          m_data_valid_i,
    input  logic [I2C_BYTE_W-1:0]         m_data_i,
    input  logic                          m_busy_i,
    input  logic                          m_error_i
);

    // Elaboration-time parameter sanity check.
    if (N_REQ < 2 || N_REQ > MAX_REQ || START_TIMEOUT == 0) begin : g_param_check
        $error("i2c_arbiter: N_REQ must be 2..8 and START_TIMEOUT nonzero");
    end

    arb_state_e            state_q, state_d;
    logic [N_REQ-1:0]      grant_q, grant_d;
    logic [N_REQ-1:0]      done_q, done_d;
    logic [N_REQ-1:0]      error_q, error_d;
    logic                  strobe_q, strobe_d;
    logic [I2C_BYTE_W-1:0] ctrl_q, ctrl_d;
    logic [I2C_BYTE_W-1:0] len_q, len_d;
    logic                  err_acc_q, err_acc_d;
    logic                  update_c;
    logic [N_REQ-1:0]      pick_c;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(START_TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    i2c_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .req_i    (req_i),
        .update_i (update_c),
        .pick_c   (pick_c)
    );

    // Command FSM: next state and registered outputs.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        done_d    = '0;
        error_d   = '0;
        strobe_d  = 1'b0;
        ctrl_d    = ctrl_q;
        len_d     = len_q;
        err_acc_d = err_acc_q;
        update_c  = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    update_c  = 1'b1;
                    grant_d   = pick_c;
                    err_acc_d = 1'b0;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (pick_c[i]) begin
                            ctrl_d = ctrl_wr_i[i*I2C_BYTE_W +: I2C_BYTE_W];
                            len_d  = len_rd_i[i*I2C_BYTE_W +: I2C_BYTE_W];
                        end
                    end
                    state_d = STROBE;
                end
            end
            STROBE: begin
                strobe_d  = 1'b1;
                err_acc_d = err_acc_q | m_error_i;
`ifdef I2C_ARB_TIMEOUT_EN
                to_cnt_d  = '0;
`endif
                state_d   = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                err_acc_d = err_acc_q | m_error_i;
                if (m_busy_i) begin
                    state_d = WAIT_DONE;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(START_TIMEOUT - 1)) begin
                    state_d = DONE;
                    done_d  = grant_q;
                    error_d = grant_q;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
`endif
            end
            WAIT_DONE: begin
                err_acc_d = err_acc_q | m_error_i;
                if (!m_busy_i) begin
                    state_d = DONE;
                    done_d  = grant_q;
                    error_d = grant_q & {N_REQ{err_acc_q | m_error_i}};
                end
            end
            DONE: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            done_q    <= '0;
            error_q   <= '0;
            strobe_q  <= 1'b0;
            ctrl_q    <= '0;
            len_q     <= '0;
            err_acc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            error_q   <= error_d;
            strobe_q  <= strobe_d;
            ctrl_q    <= ctrl_d;
            len_q     <= len_d;
            err_acc_q <= err_acc_d;
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) to_cnt_q <= '0;
        else         to_cnt_q <= to_cnt_d;
    end
`endif

    // Data routing: grant is zero in IDLE, so everything masks to 0 there.
    always_comb begin
        m_data_available_o = 1'b0;
        m_data_o           = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                m_data_available_o = req_data_available_i[i];
                m_data_o           = req_data_i[i*I2C_BYTE_W +: I2C_BYTE_W];
            end
        end
        req_data_read_o = grant_q & {N_REQ{m_data_read_i}};
        rd_data_valid_o = grant_q & {N_REQ{m_data_valid_i}};
    end

    assign rd_data_o      = m_data_i;
    assign grant_o        = grant_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign m_cmd_strobe_o = strobe_q;
    assign m_ctrl_wr_o    = ctrl_q;
    assign m_len_rd_o     = len_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter: randomized scoreboard bench for i2c_arbiter with a
// behavioural i2c_ctrl model and a round-robin reference schedule.
module tb_i2c_arbiter;

    localparam int N = 4;

    typedef struct {
        int         owner;
        logic [7:0] ctrl;
        logic [7:0] len;
        bit         err;
        bit         tmo;
    } exp_t;

    typedef struct {
        int delay;
        int blen;
        bit err;
        bit noresp;
    } beh_t;

    logic           clock_i = 1'b0;
    logic           reset_i = 1'b1;
    logic [N-1:0]   req_i = '0;
    logic [N*8-1:0] ctrl_wr_i = '0, len_rd_i = '0, req_data_i = '0;
    logic [N-1:0]   req_data_available_i = '0;
    logic [N-1:0]   grant_o, done_o, error_o, req_data_read_o, rd_data_valid_o;
    logic [7:0]     rd_data_o, m_ctrl_wr_o, m_len_rd_o, m_data_o;
    logic           m_cmd_strobe_o, m_data_available_o;
    logic           m_data_read_i = 1'b0, m_data_valid_i = 1'b0;
    logic [7:0]     m_data_i = '0;
    logic           m_busy_i = 1'b0, m_error_i = 1'b0;

    int   errors = 0, checks = 0;
    exp_t exp_q[$];
    beh_t beh_q[$];
    int   issued[N] = '{default: 0};
    int   served[N] = '{default: 0};
    bit   early[N]  = '{default: 0};
    bit   drop[N]   = '{default: 0};
    int   mptr = N - 1;

    always #5 clock_i = ~clock_i;

    i2c_arbiter #(.N_REQ(N), .START_TIMEOUT(16)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .req_i(req_i),
        .ctrl_wr_i(ctrl_wr_i), .len_rd_i(len_rd_i),
        .grant_o(grant_o), .done_o(done_o), .error_o(error_o),
        .req_data_available_i(req_data_available_i), .req_data_i(req_data_i),
        .req_data_read_o(req_data_read_o), .rd_data_valid_o(rd_data_valid_o),
        .rd_data_o(rd_data_o), .m_cmd_strobe_o(m_cmd_strobe_o),
        .m_ctrl_wr_o(m_ctrl_wr_o), .m_len_rd_o(m_len_rd_o),
        .m_data_available_o(m_data_available_o), .m_data_o(m_data_o),
        .m_data_read_i(m_data_read_i), .m_data_valid_i(m_data_valid_i),
        .m_data_i(m_data_i), .m_busy_i(m_busy_i), .m_error_i(m_error_i)
    );

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Requesters: hold req until all issued commands are done; early droppers
    // release req as soon as they see their grant.
    always @(negedge clock_i) begin
        for (int i = 0; i < N; i++) begin
            if (done_o[i]) served[i]++;
            if (early[i] && grant_o[i]) drop[i] = 1'b1;
            if (served[i] >= issued[i]) drop[i] = 1'b0;
            req_i[i] = (issued[i] > served[i]) && !drop[i];
        end
    end

    // Behavioural i2c_ctrl: after a strobe, wait, then hold busy with random
    // data traffic and an optional one-cycle error pulse.
    int   cst = 0, ccnt = 0;
    beh_t cb;
    always @(negedge clock_i) begin
        m_data_valid_i = 1'b0;
        m_data_read_i  = 1'b0;
        m_error_i      = 1'b0;
        m_data_i       = 8'($urandom);
        if (reset_i) begin
            cst      = 0;
            m_busy_i = 1'b0;
        end else begin
            case (cst)
                0: begin
                    m_data_valid_i = ($urandom_range(0, 3) == 0);
                    m_data_read_i  = ($urandom_range(0, 3) == 0);
                    if (m_cmd_strobe_o && beh_q.size() != 0) begin
                        cb   = beh_q.pop_front();
                        ccnt = cb.delay;
                        cst  = cb.noresp ? 3 : 1;
                    end
                end
                1: if (ccnt == 0) begin
                    m_busy_i = 1'b1;
                    ccnt     = cb.blen;
                    cst      = 2;
                end else ccnt--;
                2: begin
                    m_data_valid_i = ($urandom_range(0, 2) == 0);
                    m_data_read_i  = ($urandom_range(0, 1) == 0);
                    if (cb.err && ccnt == cb.blen / 2) m_error_i = 1'b1;
                    if (ccnt == 0) begin
                        m_busy_i = 1'b0;
                        cst      = 0;
                    end else ccnt--;
                end
                default: if (done_o != '0) cst = 0;
            endcase
        end
    end

    // Monitor: pops the expected command on each new grant and checks grant,
    // strobe, completion and data routing every cycle.
    exp_t       cur;
    bit         active = 0, done_seen = 0;
    int         strobes = 0, cyc = 0, strobe_cyc = 0;
    logic [N-1:0] oh, route;
    always @(negedge clock_i) begin
        #2;
        cyc++;
        if (reset_i) begin
            chk("reset_outputs", {grant_o, done_o, error_o, m_cmd_strobe_o, m_ctrl_wr_o,
                m_len_rd_o, m_data_available_o, m_data_o, req_data_read_o, rd_data_valid_o}, '0);
            active = 0;
        end else begin
            oh = N'(1) << cur.owner;
            if (!active && grant_o != '0) begin
                if (exp_q.size() == 0) chk("grant_unexpected", 64'(grant_o), 0);
                else begin
                    cur = exp_q.pop_front();
                    oh = N'(1) << cur.owner;
                    active = 1; done_seen = 0; strobes = 0;
                    chk("grant_onehot", 64'(grant_o), 64'(oh));
                end
            end else if (active && done_seen) begin
                chk("grant_release", 64'(grant_o), 0);
                active = 0;
            end else if (active) chk("grant_hold", 64'(grant_o), 64'(oh));
            else chk("grant_idle", 64'(grant_o), 0);
            route = active ? oh : '0;

            if (m_cmd_strobe_o) begin
                strobes++;
                strobe_cyc = cyc;
                chk("strobe_owned", 64'(active), 1);
                chk("strobe_no_busy", 64'(m_busy_i), 0);
                chk("strobe_count", 64'(strobes), 1);
                if (active) begin
                    chk("strobe_ctrl", 64'(m_ctrl_wr_o), 64'(cur.ctrl));
                    chk("strobe_len", 64'(m_len_rd_o), 64'(cur.len));
                end
            end

            if (done_o != '0 || error_o != '0) begin
                if (active && !done_seen) begin
                    chk("done_owner", 64'(done_o), 64'(oh));
                    chk("done_error", 64'(error_o), cur.err ? 64'(oh) : 64'(0));
                    chk("done_strobes", 64'(strobes), 1);
                    if (cur.tmo) chk("timeout_cycles", 64'(cyc - strobe_cyc), 16);
                    done_seen = 1;
                end else chk("done_unexpected", 64'(done_o), 0);
            end

            chk("rd_valid_route", 64'(rd_data_valid_o), m_data_valid_i ? 64'(route) : 64'(0));
            chk("wr_read_route", 64'(req_data_read_o), m_data_read_i ? 64'(route) : 64'(0));
            chk("rd_data", 64'(rd_data_o), 64'(m_data_i));
            chk("m_avail_route", 64'(m_data_available_o),
                active ? 64'(req_data_available_i[cur.owner]) : 64'(0));
            chk("m_data_route", 64'(m_data_o),
                active ? 64'(req_data_i[cur.owner*8 +: 8]) : 64'(0));
        end
    end

    // Reference schedule: each pending requester is served in turn starting
    // after the last winner until every requested command is accounted for.
    task automatic schedule(input int cnt[N]);
        int  rem[N];
        bit  any, found;
        int  idx;
        bit  e;
        rem = cnt;
        any = 1;
        while (any) begin
            found = 0;
            for (int k = 1; k <= N && !found; k++) begin
                idx = (mptr + k) % N;
                if (rem[idx] > 0) begin
                    e = ($urandom_range(0, 3) == 0);
                    exp_q.push_back('{idx, ctrl_wr_i[idx*8 +: 8], len_rd_i[idx*8 +: 8], e, 1'b0});
                    beh_q.push_back('{$urandom_range(0, 4), $urandom_range(2, 12), e, 1'b0});
                    rem[idx]--;
                    mptr  = idx;
                    found = 1;
                end
            end
            any = found;
        end
        for (int i = 0; i < N; i++) issued[i] += cnt[i];
    endtask

    task automatic wait_idle(input int budget);
        bit idle = 0;
        for (int k = 0; k < budget && !idle; k++) begin
            @(negedge clock_i);
            idle = (grant_o == '0);
            for (int i = 0; i < N; i++) if (served[i] != issued[i]) idle = 0;
        end
        chk("scenario_complete", 64'(idle), 1);
        chk("exp_drained", 64'(exp_q.size()), 0);
        repeat (2) @(negedge clock_i);
    endtask

    task automatic do_reset();
        @(negedge clock_i);
        #1 reset_i = 1'b1;
        repeat (2) @(negedge clock_i);
        exp_q.delete();
        beh_q.delete();
        mptr = N - 1;
        for (int i = 0; i < N; i++) begin
            issued[i] = served[i];
            early[i]  = 0;
        end
        reset_i = 1'b0;
        repeat (2) @(negedge clock_i);
    endtask

    initial begin
        int cnt[N];
        int tot, pre;
        bit hit;
        repeat (3) @(negedge clock_i);
        reset_i = 1'b0;
        repeat (2) @(negedge clock_i);

        // Single requester 0, ctrl 5a, 10-cycle busy, no error.
        ctrl_wr_i[7:0] = 8'h5a;
        len_rd_i[7:0]  = 8'h00;
        exp_q.push_back('{0, 8'h5a, 8'h00, 1'b0, 1'b0});
        beh_q.push_back('{1, 10, 1'b0, 1'b0});
        mptr = 0;
        issued[0]++;
        wait_idle(200);

        // Randomized bursts of simultaneous requests.
        for (int s = 0; s < 30; s++) begin
            tot = 0;
            for (int i = 0; i < N; i++) begin
                ctrl_wr_i[i*8 +: 8]     = 8'($urandom);
                len_rd_i[i*8 +: 8]      = 8'($urandom_range(0, 4));
                req_data_i[i*8 +: 8]    = 8'($urandom);
                req_data_available_i[i] = 1'($urandom);
                cnt[i]   = $urandom_range(0, 2);
                early[i] = (cnt[i] == 1) && ($urandom_range(0, 3) == 0);
                tot     += cnt[i];
            end
            if (tot == 0) cnt[$urandom_range(0, N - 1)] = 1;
            schedule(cnt);
            wait_idle(800);
            for (int i = 0; i < N; i++) early[i] = 0;
        end

        // Reset during WAIT_DONE: no done pulse, outputs cleared.
        exp_q.push_back('{1, ctrl_wr_i[15:8], len_rd_i[15:8], 1'b0, 1'b0});
        beh_q.push_back('{2, 20, 1'b0, 1'b0});
        pre = served[1];
        issued[1]++;
        hit = 0;
        for (int k = 0; k < 60 && !hit; k++) begin
            @(negedge clock_i);
            hit = m_busy_i;
        end
        chk("busy_rise_before_reset", 64'(hit), 1);
        repeat (3) @(negedge clock_i);
        do_reset();
        chk("no_done_on_reset", 64'(served[1]), 64'(pre));

        // All four requesting after reset, requester 0 twice: 0,1,2,3,0.
        cnt = '{2, 1, 1, 1};
        schedule(cnt);
        chk("first_after_reset", 64'(exp_q[0].owner), 0);
        wait_idle(800);

        // Controller never raises busy.
        exp_q.push_back('{3, ctrl_wr_i[31:24], len_rd_i[31:24], 1'b1, 1'b1});
        beh_q.push_back('{0, 0, 1'b0, 1'b1});
        mptr = 3;
        pre = served[3];
        issued[3]++;
`ifdef I2C_ARB_TIMEOUT_EN
        wait_idle(200);
`else
        repeat (40) @(negedge clock_i);
        chk("hang_grant_held", 64'(grant_o), 64'(4'b1000));
        chk("hang_no_done", 64'(served[3]), 64'(pre));
        do_reset();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_arbiter.md
Name: i2c_arbiter

Overview:
- Shares one i2c_ctrl instance between N_REQ independent requesters (sensor init, EEPROM, PMIC agents).
- Round-robin arbitration, one whole I2C command per grant.
- Drives i2c_ctrl's command strobe, control byte, read length and write-data handshake; routes read data and completion status back to the owner.
- Sits directly in front of i2c_ctrl, in the same clock domain.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- START_TIMEOUT, 16, cycles allowed from strobe to busy rise (used only with I2C_ARB_TIMEOUT_EN).

Ports:
- clock_i  in  1  system clock.
- reset_i  in  1  asynchronous, active-high reset.
- req_i  in  N_REQ  level request per requester.
- ctrl_wr_i  in  N_REQ*8  per-requester control byte; stable while req high.
- len_rd_i  in  N_REQ*8  per-requester read length; stable while req high.
- grant_o  out  N_REQ  one-hot owner, held for the whole command.
- done_o  out  N_REQ  one-cycle completion pulse to owner.
- error_o  out  N_REQ  owner error status; valid only with done_o.
- req_data_available_i  in  N_REQ  per-requester write byte available.
- req_data_i  in  N_REQ*8  per-requester write byte.
- req_data_read_o  out  N_REQ  write byte consumed (owner only).
- rd_data_valid_o  out  N_REQ  read byte valid (owner only).
- rd_data_o  out  8  shared read byte.
- m_cmd_strobe_o  out  1  to i2c_ctrl cmd_strobe_i.
- m_ctrl_wr_o  out  8  to ctrl_wr_i.
- m_len_rd_o  out  8  to len_rd_i.
- m_data_available_o  out  1  to data_available_i.
- m_data_o  out  8  to data_i.
- m_data_read_i  in  1  from data_read_o.
- m_data_valid_i  in  1  from data_valid_o.
- m_data_i  in  8  from data_o.
- m_busy_i  in  1  from busy_o.
- m_error_i  in  1  from error_o.

Behaviour:
- Reset: state IDLE; grant_o, done_o, error_o, m_cmd_strobe_o all 0; m_ctrl_wr_o and m_len_rd_o 0; RR pointer = N_REQ-1, so requester 0 wins first.
- IDLE:
  - If any req_i is high, select the first set bit searching from pointer+1 modulo N_REQ.
  - Register the one-hot grant, copy the winner's ctrl/len into m_ctrl_wr_o/m_len_rd_o, update pointer to the winner, go to STROBE.
  - grant_o rises 1 cycle after req is sampled.
- STROBE: m_cmd_strobe_o=1 for exactly one cycle, then WAIT_BUSY.
- WAIT_BUSY: stay until m_busy_i=1, then WAIT_DONE.
- WAIT_DONE: stay until m_busy_i=0, then DONE.
- DONE:
  - done_o[owner]=1 for one cycle.
  - error_o[owner] = sticky OR of m_error_i sampled from STROBE through this cycle.
  - grant_o clears on the next cycle; return to IDLE.
- Minimum request-to-strobe latency is 2 cycles. After DONE there is at least one IDLE cycle before the next grant, so strobes never overlap a busy command.
- Data routing is combinational and zero-latency.
  - To the controller: m_data_available_o = req_data_available_i[owner], m_data_o = req_data_i[owner].
  - To the owner: req_data_read_o[owner] = m_data_read_i, rd_data_valid_o[owner] = m_data_valid_i.
  - rd_data_o = m_data_i always.
  - Non-owners, and all requesters in IDLE, see 0 on these outputs.
- req_i dropped after grant: the command still completes and done_o still pulses.
- Owner holding req_i through DONE: re-granted only if no other requester is pending (round-robin fairness).
- Simultaneous requests: pure round-robin order; no priority inversion.
- m_busy_i high while in IDLE (stale): ignored.
- Reset mid-command: immediate return to reset state, with no done pulse. i2c_ctrl shares the same reset.

Optional Feature:
- I2C_ARB_TIMEOUT_EN defined: a counter runs in WAIT_BUSY. If START_TIMEOUT cycles elapse without m_busy_i, go to DONE with error_o[owner]=1.
- I2C_ARB_TIMEOUT_EN undefined: WAIT_BUSY waits indefinitely; START_TIMEOUT is unused and no counter is synthesised.

Decomposition:
- Package i2c_arb_pkg holds:
  - state enum {IDLE, STROBE, WAIT_BUSY, WAIT_DONE, DONE};
  - I2C_BYTE_W=8;
  - a round-robin pick function (pointer, request vector -> one-hot).
- Sub-module i2c_rr_arbiter holds the pointer register plus the combinational one-hot pick. The FSM and muxing stay in the top.

Test Plan:
- req_i=4'b0001, ctrl 8'h5a, busy model high for 10 cycles -> grant_o=0001 one cycle later; one m_cmd_strobe_o with m_ctrl_wr_o=5a; done_o=0001 after busy falls; error_o=0.
- req_i=4'b1111 held after reset -> grants in order 0001, 0010, 0100, 1000, 0001; exactly one strobe per grant; no strobe while m_busy_i=1.
- Owner 2 with len_rd 8'h03, three m_data_valid_i pulses with data 11/22/33 -> rd_data_valid_o=0100 three times, rd_data_o matches; req_data_read_o follows m_data_read_i for owner 2 only.
- m_error_i pulsed for one cycle mid-busy for owner 1 -> done_o=0010 with error_o=0010. Next command for owner 0 without error -> error_o=0.
- With I2C_ARB_TIMEOUT_EN, busy never rises -> done_o and error_o for the owner 16 cycles after the strobe. Without the macro, the FSM stays in WAIT_BUSY and grant_o is held.
- reset_i asserted in WAIT_DONE -> all outputs 0 asynchronously, no done pulse. After release, requester 0 is granted first.
